torus_tb_source: RTL and testbench

- Per-node traffic source that feeds the local injection port of a torus_switch_credit router.
- Generates N_PACKETS packets toward every other node in rotation.
- Injection is shaped by a token bucket of depth SIGMA, refilled once every RATE cycles.
- Output is throttled by per-VC credit counters that the downstream switch replenishes. done is asserted once all packets are sent and all credits have returned.

---
 rtl/torus_tb_source.sv | 201 ++++++++++++++++++++
 tb/tb_torus_tb_source.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/torus_tb_source.sv
// torus_tb_source: per-node traffic source for a torus router.
// Token-bucket shaped, credit throttled; PERF_CNT_EN adds stall_cnt.
module torus_tb_source #(
   parameter int SIGMA     = 3,
   parameter int RATE      = 20,
   parameter int VC_W      = 3,
   parameter int CRED      = 4,
   parameter int X_W       = 2,
   parameter int Y_W       = 2,
   parameter int D_W       = 32,
   parameter int N_PACKETS = 128,
   parameter int X         = 0,
   parameter int Y         = 0,
   parameter int X_MAX     = 1 << X_W,
   parameter int Y_MAX     = 1 << Y_W
) (
   input  logic            clk,
   input  logic            rst,
   output logic            o_v,
   output logic [X_W-1:0]  o_x,
   output logic [Y_W-1:0]  o_y,
   output logic [D_W-1:0]  o_data,
   output logic [VC_W-1:0] o_vc,
   input  logic            i_ack,
   input  logic [VC_W-1:0] i_credit,
   output logic            done
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]     stall_cnt
`endif
);

   localparam int TOK_W = $clog2(SIGMA + 1);
   localparam int CR_W  = $clog2(CRED + 1);
   localparam int RC_W  = (RATE > 1) ? $clog2(RATE) : 1;
   localparam int SEQ_W = $clog2(N_PACKETS + 1);
   localparam int VP_W  = (VC_W > 1) ? $clog2(VC_W) : 1;
   localparam int N     = X_MAX * Y_MAX;
   localparam int SELF  = Y * X_MAX + X;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state;
   logic [TOK_W-1:0] tokens;
   logic [RC_W-1:0]  rate_cnt;
   logic [CR_W-1:0]  credit [VC_W];
   logic [SEQ_W-1:0] seq;
   logic [VP_W-1:0]  vc_ptr;

   logic             refill;
   logic             more;
   logic             launch;
   logic             pick_ok;
   logic             all_full;
   logic [VP_W-1:0]  pick;
   logic [VP_W-1:0]  idx;
   logic [VC_W-1:0]  has_cred;
   logic [VC_W-1:0]  cons;
   logic [TOK_W:0]   tok_sum;
   logic [TOK_W-1:0] tokens_nxt;
   logic [CR_W:0]    cr_sum [VC_W];
   logic [CR_W-1:0]  credit_nxt [VC_W];
   int               dest;
   logic [X_W-1:0]   x_nxt;
   logic [Y_W-1:0]   y_nxt;
   logic [D_W-1:0]   data_nxt;

   assign refill = (rate_cnt == RC_W'(RATE - 1));
   assign more   = (seq != SEQ_W'(N_PACKETS));
   assign launch = (state == S_IDLE) && more
                   && (tokens != '0) && pick_ok;
   assign cons   = launch ? (VC_W'(1) << pick) : '0;

   // which VCs can take a packet right now
   always_comb begin
      has_cred = '0;
      for (int v = 0; v < VC_W; v++) begin
         has_cred[v] = (credit[v] != '0);
      end
   end

   // round-robin pick: first VC with credit, starting at vc_ptr
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      idx     = '0;
      for (int i = VC_W - 1; i >= 0; i--) begin
         idx = VP_W'((int'(vc_ptr) + i) % VC_W);
         if (has_cred[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   // bucket and credit updates; return and consume cancel out
   always_comb begin
      tok_sum = {1'b0, tokens} + {{TOK_W{1'b0}}, refill}
                - {{TOK_W{1'b0}}, launch};
      tokens_nxt = (tok_sum > (TOK_W + 1)'(SIGMA))
                   ? TOK_W'(SIGMA) : tok_sum[TOK_W-1:0];
      all_full = 1'b1;
      for (int v = 0; v < VC_W; v++) begin
         cr_sum[v] = {1'b0, credit[v]}
                     + {{CR_W{1'b0}}, i_credit[v]}
                     - {{CR_W{1'b0}}, cons[v]};
         credit_nxt[v] = (cr_sum[v] > (CR_W + 1)'(CRED))
                         ? CR_W'(CRED) : cr_sum[v][CR_W-1:0];
         if (credit_nxt[v] != CR_W'(CRED)) all_full = 1'b0;
      end
   end

   // destination rotates over every node except this one
   always_comb begin
      dest     = (SELF + 1 + (int'(seq) % (N - 1))) % N;
      x_nxt    = X_W'(dest % X_MAX);
      y_nxt    = Y_W'(dest / X_MAX);
      data_nxt = '0;
      data_nxt[D_W-1 -: X_W]       = X_W'(X);
      data_nxt[D_W-X_W-1 -: Y_W]   = Y_W'(Y);
      data_nxt[SEQ_W-1:0]          = seq;
   end

   // token bucket and per-VC credit counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tokens   <= TOK_W'(SIGMA);
         rate_cnt <= '0;
         for (int v = 0; v < VC_W; v++) credit[v] <= CR_W'(CRED);
      end else begin
         tokens   <= tokens_nxt;
         rate_cnt <= refill ? '0 : rate_cnt + RC_W'(1);
         for (int v = 0; v < VC_W; v++) credit[v] <= credit_nxt[v];
      end
   end

   // packet FSM with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         o_v    <= 1'b0;
         o_x    <= '0;
         o_y    <= '0;
         o_data <= '0;
         o_vc   <= '0;
         done   <= 1'b0;
         seq    <= '0;
         vc_ptr <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (!more) begin
                  state <= S_DRAIN;
               end else if (launch) begin
                  o_v    <= 1'b1;
                  o_x    <= x_nxt;
                  o_y    <= y_nxt;
                  o_data <= data_nxt;
                  o_vc   <= cons;
                  vc_ptr <= (pick == VP_W'(VC_W - 1))
                            ? '0 : pick + VP_W'(1);
                  state  <= S_SEND;
               end
            end
            S_SEND: begin
               if (i_ack) begin
                  o_v   <= 1'b0;
                  seq   <= seq + SEQ_W'(1);
                  state <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (all_full) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: done <= 1'b1;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef PERF_CNT_EN
   // count IDLE cycles held back only by missing credit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (state == S_IDLE && more && tokens != '0
                   && !pick_ok && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_torus_tb_source.sv
// tb_torus_tb_source: directed bench for torus_tb_source.
// Default parameters: 4x4 torus, node (0,0), SIGMA=3, RATE=20.
module tb_torus_tb_source;

   logic        clk;
   logic        rst;
   logic        o_v;
   logic [1:0]  o_x;
   logic [1:0]  o_y;
   logic [31:0] o_data;
   logic [2:0]  o_vc;
   logic        i_ack;
   logic [2:0]  i_credit;
   logic        done;
`ifdef PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc;
   int          last_cred_cyc;
   int          done_cyc;
   int          bad;
   int          bad2;
   int          dexp;
   logic        prev_ov;
   logic        auto_cred;
   logic [2:0]  pend1;
   logic [39:0] snap;
   bit          seen [256];

   int          lc [$];
   logic [31:0] ld [$];
   logic [1:0]  lx [$];
   logic [1:0]  ly [$];
   logic [2:0]  lv [$];

   torus_tb_source dut (
      .clk      (clk),
      .rst      (rst),
      .o_v      (o_v),
      .o_x      (o_x),
      .o_y      (o_y),
      .o_data   (o_data),
      .o_vc     (o_vc),
      .i_ack    (i_ack),
      .i_credit (i_credit),
      .done     (done)
`ifdef PERF_CNT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: returns credits 2 cycles after each ack, logs launches
   task automatic tick();
      logic       fire;
      logic [2:0] fvc;
      logic [2:0] cpre;
      fire = o_v & i_ack;
      fvc  = o_vc;
      cpre = i_credit;
      @(posedge clk);
      #1;
      cyc++;
      if (cpre != 3'b000) last_cred_cyc = cyc;
      i_credit = pend1;
      pend1 = (auto_cred && fire) ? fvc : 3'b000;
      if (o_v && !prev_ov) begin
         lc.push_back(cyc);
         ld.push_back(o_data);
         lx.push_back(o_x);
         ly.push_back(o_y);
         lv.push_back(o_vc);
      end
      prev_ov = o_v;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      i_ack = 1'b0;
      i_credit = 3'b000;
      pend1 = 3'b000;
      repeat (2) tick();
      rst = 1'b1;
      cyc = 0;
      last_cred_cyc = -1;
      prev_ov = 1'b0;
      lc.delete();
      ld.delete();
      lx.delete();
      ly.delete();
      lv.delete();
   endtask

   initial begin
      rst = 1'b1;
      i_ack = 1'b0;
      i_credit = 3'b000;
      pend1 = 3'b000;
      auto_cred = 1'b0;
      cyc = 0;
      prev_ov = 1'b0;
      last_cred_cyc = -1;
      #1 rst = 1'b0;
      #2;
      chk("rst_o_v", o_v, 0);
      chk("rst_o_x", o_x, 0);
      chk("rst_o_y", o_y, 0);
      chk("rst_o_data", o_data, 0);
      chk("rst_o_vc", o_vc, 0);
      chk("rst_done", done, 0);
`ifdef PERF_CNT_EN
      chk("rst_stall", stall_cnt, 0);
`endif

      // burst, shaping and destination rotation
      do_reset();
      auto_cred = 1'b1;
      i_ack = 1'b1;
      for (int k = 0; k < 600 && lc.size() < 17; k++) tick();
      i_ack = 1'b0;
      chk("a_count", lc.size(), 17);
      chk("a_t0", lc[0], 1);
      chk("a_t1", lc[1], 3);
      chk("a_t2", lc[2], 5);
      chk("a_t3", lc[3], 21);
      chk("a_t4", lc[4], 41);
      chk("a_t5", lc[5], 61);
      chk("a_t16", lc[16], 281);
      chk("a_p0", {lx[0], ly[0]}, {2'd1, 2'd0});
      chk("a_p1", {lx[1], ly[1]}, {2'd2, 2'd0});
      chk("a_p2", {lx[2], ly[2]}, {2'd3, 2'd0});
      chk("a_p3", {lx[3], ly[3]}, {2'd0, 2'd1});
      chk("a_p14", {lx[14], ly[14]}, {2'd3, 2'd3});
      chk("a_p15", {lx[15], ly[15]}, {2'd1, 2'd0});
      bad = 0;
      bad2 = 0;
      for (int k = 0; k < lc.size(); k++) begin
         if (ld[k] !== 32'(k)) bad++;
         if (lv[k] !== 3'(1 << (k % 3))) bad2++;
      end
      chk("a_seq_data", bad, 0);
      chk("a_vc_rr", bad2, 0);

      // backpressure: hold the packet for 50 cycles
      snap = {o_x, o_y, o_data, o_vc, o_v};
      repeat (50) begin
         tick();
         chk("bp_hold", {o_x, o_y, o_data, o_vc, o_v}, snap);
      end
      chk("bp_tokens", dut.tokens, 2);
      chk("bp_credits", int'(dut.credit[0]) + int'(dut.credit[1])
          + int'(dut.credit[2]), 11);
      i_ack = 1'b1;
      tick();
      chk("bp_drop", o_v, 0);
      tick();
      chk("bp_next", o_v, 1);

      // asynchronous reset while o_v is high
      i_ack = 1'b0;
      rst = 1'b0;
      #1;
      chk("ar_o_v", o_v, 0);
      chk("ar_done", done, 0);
      do_reset();
      auto_cred = 1'b1;
      i_ack = 1'b1;
      i_credit = 3'b001;
      tick();
      chk("c_coincide", dut.credit[0], 4);
      for (int k = 0; k < 40 && lc.size() < 3; k++) tick();
      chk("c_count", lc.size(), 3);
      chk("c_t0", lc[0], 1);
      chk("c_t1", lc[1], 3);
      chk("c_t2", lc[2], 5);
      chk("c_seq0", ld[0], 0);
      chk("c_vc0", lv[0], 3'b001);

      // credit exhaustion: nothing ever returned
      do_reset();
      auto_cred = 1'b0;
      i_ack = 1'b1;
      repeat (400) tick();
      chk("d_count", lc.size(), 12);
      chk("d_t11", lc[11], 181);
      bad = 0;
      for (int k = 0; k < lc.size(); k++) begin
         if (lv[k] !== 3'(1 << (k % 3))) bad++;
      end
      chk("d_vc_rr", bad, 0);
      chk("d_o_v", o_v, 0);
      chk("d_done", done, 0);
`ifdef PERF_CNT_EN
      chk("d_stall", stall_cnt, 200);
      tick();
      chk("d_stall_inc", stall_cnt, 201);
`endif

      // full run to completion
      do_reset();
      auto_cred = 1'b1;
      i_ack = 1'b1;
      for (int k = 0; k < 3200 && !done; k++) tick();
      done_cyc = cyc;
      chk("e_done", done, 1);
      chk("e_count", lc.size(), 128);
      chk("e_done_cyc", done_cyc, 2504);
      chk("e_after_cred", done_cyc, last_cred_cyc);
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      bad = 0;
      bad2 = 0;
      for (int k = 0; k < lc.size(); k++) begin
         if (ld[k][31:7] != 25'd0 || seen[ld[k][7:0]]) bad++;
         seen[ld[k][7:0]] = 1'b1;
         dexp = (1 + (k % 15)) % 16;
         if ({ly[k], lx[k]} !== 4'(dexp)) bad2++;
         if ({lx[k], ly[k]} === 4'b0000) bad2++;
      end
      chk("e_seq_once", bad, 0);
      chk("e_dest", bad2, 0);
      repeat (10) tick();
      chk("e_hold", done, 1);
      chk("e_quiet", o_v, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
